// File: rtl/sme_collect_pkg.sv
// Shared types for the SME match collector: the per-packet record layout and rule ID width.
// The record is what the core pops for each packet, alongside that packet's rule IDs.
package sme_collect_pkg;

   localparam int RULE_ID_W = 16;
   localparam int CNT_W     = 8;

   typedef struct packed {
      logic             ovf;
      logic [CNT_W-1:0] count;
   } sme_rec_t;

   localparam int REC_W = $bits(sme_rec_t);

   function automatic sme_rec_t make_rec(input logic ovf, input logic [CNT_W-1:0] count);
      sme_rec_t r;
      r.ovf   = ovf;
      r.count = count;
      return r;
   endfunction

endpackage

// File: rtl/simple_fifo.sv
// Synchronous show-ahead FIFO: the head entry is presented on pop_data whenever empty is low.
// A push is ignored when full and a pop is ignored when empty.
module simple_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH_LOG  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG:0] PTR_ONE = {{DEPTH_LOG{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH_LOG:0]    wr_ptr;
   logic [DEPTH_LOG:0]    rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   // The extra pointer bit tells a full FIFO apart from an empty one.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[DEPTH_LOG] != rd_ptr[DEPTH_LOG]) &&
                     (wr_ptr[DEPTH_LOG-1:0] == rd_ptr[DEPTH_LOG-1:0]);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr[DEPTH_LOG-1:0]];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[DEPTH_LOG-1:0]] <= push_data;
   end

endmodule

// File: rtl/sme_match_collector.sv
// Consumer side of the SME match interface: pops rule IDs, groups them per packet and
// queues the IDs plus one {ovf,count} record per packet for the RISC-V core to drain.
module sme_match_collector
   import sme_collect_pkg::*;
#(
   parameter int ID_DEPTH_LOG  = 5,
   parameter int REC_DEPTH_LOG = 3,
   parameter int MAX_IDS       = 16,
   parameter int PEND_W        = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [RULE_ID_W-1:0] match_rule_ID,
   input  logic                 match_valid,
   input  logic                 match_last,
   output logic                 match_release,
   output logic                 rec_valid,
   output logic [CNT_W-1:0]     rec_count,
   output logic                 rec_ovf,
   input  logic                 rec_ready,
   output logic                 id_valid,
   output logic [RULE_ID_W-1:0] id_data,
   input  logic                 id_ready,
   output logic                 err_lost_last,
   output logic [31:0]          stat_pkt_cnt,
   output logic [31:0]          stat_drop_cnt
);

   localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_IDS);
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

   logic              id_full;
   logic              id_empty;
   logic              rec_full;
   logic              rec_empty;
   sme_rec_t          rec_head;
   sme_rec_t          rec_in;
   sme_rec_t          stash_reg;
   logic              stash_valid;
   logic [PEND_W-1:0] pend;
   logic [CNT_W-1:0]  cur_cnt;
   logic              cur_ovf;

   logic              accept;
   logic              close_now;
   logic              drain;
   logic              lost;
   logic              pend_inc;
   logic [CNT_W-1:0]  base_cnt;
   logic              base_ovf;
   logic              id_push;
   logic              drop;
   logic              rec_push;

   // Release depends only on registered state (and reset), never on match_valid.
   assign match_release = !rst && !id_full && (pend == '0);

   always_comb begin
      accept    = match_valid && match_release;
      close_now = match_last && (pend == '0);
      drain     = (pend != '0) && !rec_full;
      lost      = match_last && (&pend) && rec_full;
      pend_inc  = match_last && ((pend != '0) || rec_full) && !lost;
      // An ID arriving together with match_last belongs to the packet that starts after the close.
      base_cnt  = close_now ? '0 : cur_cnt;
      base_ovf  = close_now ? 1'b0 : cur_ovf;
      id_push   = accept && (base_cnt < MAX_CNT);
      drop      = accept && !(base_cnt < MAX_CNT);
      rec_push  = (close_now && !rec_full) || drain;
      if (pend == '0) begin
         rec_in = make_rec(cur_ovf, cur_cnt);
      end else if (stash_valid) begin
         rec_in = stash_reg;
      end else begin
         rec_in = make_rec(1'b0, '0);
      end
   end

   // Packet accounting, the pending-close backlog and the statistics counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_cnt       <= '0;
         cur_ovf       <= 1'b0;
         pend          <= '0;
         stash_reg     <= '0;
         stash_valid   <= 1'b0;
         err_lost_last <= 1'b0;
         stat_pkt_cnt  <= '0;
         stat_drop_cnt <= '0;
      end else begin
         if (accept) begin
            if (id_push) begin
               cur_cnt <= base_cnt + CNT_ONE;
               cur_ovf <= base_ovf;
            end else begin
               cur_cnt       <= base_cnt;
               cur_ovf       <= 1'b1;
               stat_drop_cnt <= stat_drop_cnt + 32'd1;
            end
         end else if (close_now) begin
            cur_cnt <= '0;
            cur_ovf <= 1'b0;
         end

         if (close_now && rec_full) begin
            stash_reg   <= make_rec(cur_ovf, cur_cnt);
            stash_valid <= 1'b1;
         end else if (drain && stash_valid) begin
            stash_valid <= 1'b0;
         end

         if (pend_inc && !drain) begin
            pend <= pend + PEND_ONE;
         end else if (drain && !pend_inc) begin
            pend <= pend - PEND_ONE;
         end

         if (lost) err_lost_last <= 1'b1;
         if (rec_push) stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
      end
   end

   simple_fifo #(
      .DATA_WIDTH (RULE_ID_W),
      .DEPTH_LOG  (ID_DEPTH_LOG)
   ) u_id_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (1'b0),
      .push      (id_push),
      .push_data (match_rule_ID),
      .pop       (id_ready),
      .pop_data  (id_data),
      .full      (id_full),
      .empty     (id_empty)
   );

   simple_fifo #(
      .DATA_WIDTH (REC_W),
      .DEPTH_LOG  (REC_DEPTH_LOG)
   ) u_rec_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (1'b0),
      .push      (rec_push),
      .push_data (rec_in),
      .pop       (rec_ready),
      .pop_data  (rec_head),
      .full      (rec_full),
      .empty     (rec_empty)
   );

   assign id_valid  = !id_empty;
   assign rec_valid = !rec_empty;
   assign rec_count = rec_head.count;
   assign rec_ovf   = rec_head.ovf;

endmodule

// File: tb/tb_sme_match_collector.sv
// Directed bench for sme_match_collector: drives the SME side and the core pop ports
// cycle by cycle and compares outputs against hand-computed expectations.
module tb_sme_match_collector;

   logic        clk;
   logic        rst;
   logic [15:0] match_rule_ID;
   logic        match_valid;
   logic        match_last;
   logic        match_release;
   logic        rec_valid;
   logic [7:0]  rec_count;
   logic        rec_ovf;
   logic        rec_ready;
   logic        id_valid;
   logic [15:0] id_data;
   logic        id_ready;
   logic        err_lost_last;
   logic [31:0] stat_pkt_cnt;
   logic [31:0] stat_drop_cnt;

   int total = 0;
   int bad   = 0;

   sme_match_collector dut (
      .clk           (clk),
      .rst           (rst),
      .match_rule_ID (match_rule_ID),
      .match_valid   (match_valid),
      .match_last    (match_last),
      .match_release (match_release),
      .rec_valid     (rec_valid),
      .rec_count     (rec_count),
      .rec_ovf       (rec_ovf),
      .rec_ready     (rec_ready),
      .id_valid      (id_valid),
      .id_data       (id_data),
      .id_ready      (id_ready),
      .err_lost_last (err_lost_last),
      .stat_pkt_cnt  (stat_pkt_cnt),
      .stat_drop_cnt (stat_drop_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One clock cycle with the given inputs; outputs are then sampled 1 time unit after the edge.
   task automatic applyStimulus(input logic v, input logic [15:0] id, input logic last,
                                input logic rr, input logic ir);
      match_valid   = v;
      match_rule_ID = id;
      match_last    = last;
      rec_ready     = rr;
      id_ready      = ir;
      @(posedge clk);
      #1;
      match_valid = 1'b0;
      match_last  = 1'b0;
      rec_ready   = 1'b0;
      id_ready    = 1'b0;
   endtask

   task automatic popRec(input string tag, input logic ovf, input logic [7:0] cnt);
      checkOutput({tag, ".rec_valid"}, 32'(rec_valid), 32'd1);
      checkOutput({tag, ".rec_count"}, 32'(rec_count), 32'(cnt));
      checkOutput({tag, ".rec_ovf"},   32'(rec_ovf),   32'(ovf));
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic popId(input string tag, input logic [15:0] id);
      checkOutput({tag, ".id_valid"}, 32'(id_valid), 32'd1);
      checkOutput({tag, ".id_data"},  32'(id_data),  32'(id));
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rst           = 1'b1;
      match_rule_ID = '0;
      match_valid   = 1'b0;
      match_last    = 1'b0;
      rec_ready     = 1'b0;
      id_ready      = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checkOutput("rst.release",   32'(match_release), 32'd0);
      checkOutput("rst.rec_valid", 32'(rec_valid),     32'd0);
      checkOutput("rst.id_valid",  32'(id_valid),      32'd0);
      checkOutput("rst.err",       32'(err_lost_last), 32'd0);
      checkOutput("rst.pkt_cnt",   stat_pkt_cnt,       32'd0);
      rst = 1'b0;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("idle.release", 32'(match_release), 32'd1);

      // 1: three IDs in one packet
      $display("[TB] basic packet");
      applyStimulus(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
      checkOutput("t1.id_latency", 32'(id_valid), 32'd1);
      applyStimulus(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0033, 1'b0, 1'b0, 1'b0);
      checkOutput("t1.no_rec_yet", 32'(rec_valid), 32'd0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("t1.pkt_cnt", stat_pkt_cnt, 32'd1);
      popRec("t1.rec", 1'b0, 8'd3);
      popId("t1.id0", 16'h0011);
      popId("t1.id1", 16'h0022);
      popId("t1.id2", 16'h0033);
      checkOutput("t1.rec_empty", 32'(rec_valid), 32'd0);
      checkOutput("t1.id_empty",  32'(id_valid),  32'd0);

      // 2: overflow past MAX_IDS
      $display("[TB] overflow packet");
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0);
      checkOutput("t2.release", 32'(match_release), 32'd1);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("t2.drop_cnt", stat_drop_cnt, 32'd4);
      popRec("t2.rec", 1'b1, 8'd16);
      for (int i = 0; i < 16; i++) popId($sformatf("t2.id%0d", i), 16'h0100 + 16'(i));
      checkOutput("t2.id_empty", 32'(id_valid), 32'd0);
      checkOutput("t2.pkt_cnt", stat_pkt_cnt, 32'd2);

      // 3: record FIFO full, pending closes, backlog drain
      $display("[TB] pending closes");
      for (int k = 0; k < 9; k++) begin
         applyStimulus(1'b1, 16'h0200 + 16'(k), 1'b0, 1'b0, 1'b0);
         applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("t3.release_pend1", 32'(match_release), 32'd0);
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("t3.release_pend4", 32'(match_release), 32'd0);
      checkOutput("t3.err", 32'(err_lost_last), 32'd0);
      for (int k = 0; k < 9; k++) popRec($sformatf("t3.rec%0d", k), 1'b0, 8'd1);
      for (int k = 9; k < 12; k++) popRec($sformatf("t3.rec%0d", k), 1'b0, 8'd0);
      checkOutput("t3.rec_empty", 32'(rec_valid), 32'd0);
      checkOutput("t3.release_back", 32'(match_release), 32'd1);
      checkOutput("t3.pkt_cnt", stat_pkt_cnt, 32'd14);
      for (int k = 0; k < 9; k++) popId($sformatf("t3.id%0d", k), 16'h0200 + 16'(k));

      // 4: ID accepted in the same cycle as match_last
      $display("[TB] same-cycle last");
      applyStimulus(1'b1, 16'h0301, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0302, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      popRec("t4.rec0", 1'b0, 8'd2);
      popRec("t4.rec1", 1'b0, 8'd1);
      popId("t4.id0", 16'h0301);
      popId("t4.id1", 16'h0302);
      popId("t4.id2", 16'h00AA);
      checkOutput("t4.pkt_cnt", stat_pkt_cnt, 32'd16);

      // 5: ID FIFO full back-pressure
      $display("[TB] id fifo full");
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, 16'h0400 + 16'(i), 1'b0, 1'b0, 1'b0);
         if (i == 15 || i == 31) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("t5.release_full", 32'(match_release), 32'd0);
      checkOutput("t5.head", 32'(id_data), 32'h0400);
      applyStimulus(1'b1, 16'h0420, 1'b0, 1'b0, 1'b1);
      checkOutput("t5.release_resume", 32'(match_release), 32'd1);
      applyStimulus(1'b1, 16'h0420, 1'b0, 1'b0, 1'b0);
      checkOutput("t5.release_refull", 32'(match_release), 32'd0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("t5.drop_cnt", stat_drop_cnt, 32'd4);
      checkOutput("t5.pkt_cnt", stat_pkt_cnt, 32'd19);
      popRec("t5.rec0", 1'b0, 8'd16);
      popRec("t5.rec1", 1'b0, 8'd16);
      popRec("t5.rec2", 1'b0, 8'd1);
      for (int i = 1; i < 33; i++) popId($sformatf("t5.id%0d", i), 16'h0400 + 16'(i));
      checkOutput("t5.id_empty", 32'(id_valid), 32'd0);

      // 6: reset in the middle of a packet
      $display("[TB] mid-packet reset");
      applyStimulus(1'b1, 16'h0501, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0502, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0503, 1'b0, 1'b0, 1'b0);
      checkOutput("t6.pre_rec", 32'(rec_valid), 32'd1);
      rst = 1'b1;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("t6.rec_valid", 32'(rec_valid),     32'd0);
      checkOutput("t6.id_valid",  32'(id_valid),      32'd0);
      checkOutput("t6.pkt_cnt",   stat_pkt_cnt,       32'd0);
      checkOutput("t6.drop_cnt",  stat_drop_cnt,      32'd0);
      checkOutput("t6.err",       32'(err_lost_last), 32'd0);
      checkOutput("t6.release",   32'(match_release), 32'd0);
      rst = 1'b0;
      applyStimulus(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0033, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("t6.pkt_cnt_new", stat_pkt_cnt, 32'd1);
      popRec("t6.rec", 1'b0, 8'd3);
      popId("t6.id0", 16'h0011);
      popId("t6.id1", 16'h0022);
      popId("t6.id2", 16'h0033);
      checkOutput("t6.id_empty", 32'(id_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
